// File: rtl/onehot_seq_pkg.sv
// onehot_seq_pkg: shared types and reference one-hot helper for the sequenced decoder
package onehot_seq_pkg;
  localparam int MAX_SEL_W = 6;
  typedef enum logic {MODE_DIRECT, MODE_SWEEP} mode_e;
  typedef enum logic {S_IDLE, S_EMIT} state_e;
  function automatic logic [2**MAX_SEL_W-1:0] onehot_f(input logic [MAX_SEL_W-1:0] idx);
    return {{(2**MAX_SEL_W-1){1'b0}}, 1'b1} << idx;
  endfunction
endpackage

// File: rtl/onehot_seq_decoder_dec.sv
// onehot_dec: combinational index-to-one-hot decoder, all zeros when disabled
module onehot_dec #(
  parameter int SEL_W = 3
) (
  input  logic                  en_i,
  input  logic [SEL_W-1:0]      idx_i,
  output logic [2**SEL_W-1:0]   onehot_o
);
  localparam int OUT_W = 2**SEL_W;
  assign onehot_o = en_i ? {{(OUT_W-1){1'b0}}, 1'b1} << idx_i : '0;
endmodule

// File: rtl/onehot_seq_decoder.sv
// onehot_seq_decoder: registered one-hot decoder with direct and wrapping sweep modes
module onehot_seq_decoder
  import onehot_seq_pkg::*;
#(
  parameter int SEL_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic                in_mode_i,
  input  logic [SEL_W-1:0]    in_sel_i,
  input  logic [SEL_W-1:0]    in_count_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [2**SEL_W-1:0] out_onehot_o,
  output logic [SEL_W-1:0]    out_index_o,
  output logic                out_last_o
);
  localparam int OUT_W = 2**SEL_W;
  state_e           state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d, rem_q, rem_d;
  logic [OUT_W-1:0] onehot_q, onehot_d;
  logic             last_q, last_d, accept, step, done, sweep;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  always_comb begin
    sweep   = mode_e'(in_mode_i) == MODE_SWEEP;
    accept  = in_valid_i && in_ready_o;
    step    = out_valid_o && out_ready_i && !last_q;
    done    = out_valid_o && out_ready_i && last_q;
    state_d = accept ? S_EMIT : done ? S_IDLE : state_q;
    idx_d   = accept ? in_sel_i : step ? idx_q + SEL_W'(1) : idx_q;
    rem_d   = accept ? (sweep ? in_count_i : '0) : step ? rem_q - SEL_W'(1) : rem_q;
    last_d  = accept ? (!sweep || in_count_i == '0) : step ? rem_q == SEL_W'(1) : last_q;
  end
  always_comb begin
    out_valid_o  = state_q == S_EMIT;
    in_ready_o   = !out_valid_o || (out_ready_i && last_q);
    out_onehot_o = onehot_q;
    out_index_o  = idx_q;
    out_last_o   = last_q;
  end
  // decode the next index so the output register holds a ready-made word
  onehot_dec #(.SEL_W(SEL_W)) u_dec (
    .en_i    (state_d == S_EMIT),
    .idx_i   (idx_d),
    .onehot_o(onehot_d)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx_q    <= '0;
      rem_q    <= '0;
      last_q   <= 1'b0;
      onehot_q <= '0;
    end else begin
      idx_q    <= idx_d;
      rem_q    <= rem_d;
      last_q   <= last_d;
      onehot_q <= onehot_d;
    end
  a_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    out_onehot_o == (out_valid_o ? OUT_W'(onehot_f(MAX_SEL_W'(out_index_o))) : '0));
endmodule

// File: tb/tb_onehot_seq_decoder.sv
// tb_onehot_seq_decoder: directed checks for SEL_W=3 and SEL_W=4 decoders
module tb_onehot_seq_decoder;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       in_valid, in_ready, in_mode, out_valid, out_ready, out_last;
  logic [2:0] in_sel, in_count, out_index;
  logic [7:0] out_onehot;
  logic       b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready, b_out_last;
  logic [3:0] b_in_sel, b_in_count, b_out_index;
  logic [15:0] b_out_onehot, seen;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  onehot_seq_decoder #(.SEL_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_mode_i(in_mode), .in_sel_i(in_sel), .in_count_i(in_count),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_onehot_o(out_onehot),
    .out_index_o(out_index), .out_last_o(out_last)
  );
  onehot_seq_decoder #(.SEL_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
    .in_mode_i(b_in_mode), .in_sel_i(b_in_sel), .in_count_i(b_in_count),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_onehot_o(b_out_onehot),
    .out_index_o(b_out_index), .out_last_o(b_out_last)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // popcount must track out_valid on every cycle out of reset
  always @(negedge clk)
    if (rst_n) begin
      chk("pop8", 64'($countones(out_onehot)), 64'(out_valid));
      chk("pop16", 64'($countones(b_out_onehot)), 64'(b_out_valid));
    end
  initial begin
    in_valid = 0; in_mode = 0; in_sel = 0; in_count = 0; out_ready = 1;
    b_in_valid = 0; b_in_mode = 0; b_in_sel = 0; b_in_count = 0; b_out_ready = 1;
    tick;
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_onehot", 64'(out_onehot), 0);
    chk("rst_index", 64'(out_index), 0);
    chk("rst_last", 64'(out_last), 0);
    rst_n = 1;
    chk("idle_ready", 64'(in_ready), 1);
    in_valid = 1; in_sel = 5;
    tick;
    in_valid = 0;
    chk("d5_valid", 64'(out_valid), 1);
    chk("d5_onehot", 64'(out_onehot), 64'h20);
    chk("d5_index", 64'(out_index), 5);
    chk("d5_last", 64'(out_last), 1);
    tick;
    chk("d5_done_valid", 64'(out_valid), 0);
    chk("d5_done_onehot", 64'(out_onehot), 0);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1; in_sel = 3'(i);
      chk("exh_ready", 64'(in_ready), 1);
      tick;
      chk("exh_valid", 64'(out_valid), 1);
      chk("exh_onehot", 64'(out_onehot), 64'(8'h01 << i));
    end
    in_valid = 0;
    tick;
    chk("exh_idle", 64'(out_valid), 0);
    in_valid = 1; in_mode = 1; in_sel = 6; in_count = 3;
    tick;
    in_valid = 0;
    for (int k = 0; k < 4; k++) begin
      chk("wrap_valid", 64'(out_valid), 1);
      chk("wrap_index", 64'(out_index), 64'((6 + k) % 8));
      chk("wrap_onehot", 64'(out_onehot), 64'(8'h01 << ((6 + k) % 8)));
      chk("wrap_last", 64'(out_last), 64'(k == 3));
      tick;
    end
    chk("wrap_end", 64'(out_valid), 0);
    in_valid = 1; in_sel = 0; in_count = 2;
    tick;
    in_valid = 0;
    chk("bp_idx0", 64'(out_index), 0);
    chk("bp_ready0", 64'(in_ready), 0);
    tick;
    out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      chk("bp_hold_idx", 64'(out_index), 1);
      chk("bp_hold_onehot", 64'(out_onehot), 64'h02);
      chk("bp_hold_valid", 64'(out_valid), 1);
      chk("bp_hold_ready", 64'(in_ready), 0);
      tick;
    end
    out_ready = 1;
    chk("bp_idx1", 64'(out_index), 1);
    chk("bp_ready1", 64'(in_ready), 0);
    tick;
    chk("bp_idx2", 64'(out_index), 2);
    chk("bp_last2", 64'(out_last), 1);
    chk("bp_ready2", 64'(in_ready), 1);
    tick;
    chk("bp_end", 64'(out_valid), 0);
    in_valid = 1; in_sel = 0; in_count = 7;
    tick;
    in_valid = 0;
    tick;
    tick;
    chk("mid_idx", 64'(out_index), 2);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 0);
    chk("mid_rst_onehot", 64'(out_onehot), 0);
    chk("mid_rst_index", 64'(out_index), 0);
    chk("mid_rst_last", 64'(out_last), 0);
    tick;
    rst_n = 1;
    chk("mid_rel_ready", 64'(in_ready), 1);
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("mid_no_beat", 64'(out_valid), 0);
    end
    b_in_valid = 1; b_in_mode = 1; b_in_sel = 9; b_in_count = 15;
    tick;
    b_in_valid = 0;
    seen = '0;
    for (int k = 0; k < 16; k++) begin
      chk("w16_index", 64'(b_out_index), 64'((9 + k) % 16));
      chk("w16_onehot", 64'(b_out_onehot), 64'(16'h0001 << ((9 + k) % 16)));
      chk("w16_last", 64'(b_out_last), 64'(k == 15));
      seen |= b_out_onehot;
      tick;
    end
    chk("w16_cover", 64'(seen), 64'hffff);
    chk("w16_end", 64'(b_out_valid), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
